quant_table_loader: RTL and testbench
=====================================

// Module: quant_table_loader
// PURPOSE
//   Sequences MDEC command 2 (set quant tables) into the computeCoef quant RAM write port.
//   Takes 32-bit parameter words from the command/DMA input path and packs each word's four
//   bytes into one 28-bit entry: 4 x 7 bit, MSB of each byte dropped.
//   Writes 16 entries to the luma table, then 16 to chroma when the command colour flag is set.
//   Holds off writing while coefficients are in flight, so a running block never mixes tables.
// PARAMETERS
//   TBL_WORDS   16   entries per table; also the width basis of the word counter
//   GATE_BUSY   1    1: wait for !i_pipeBusy before the first write; 0: start writing immediately
// PORTS
//   i_clk             in   1   clock
//   i_nrst            in   1   asynchronous active-low reset
//   i_cmdStart        in   1   1-cycle pulse: command 2 decoded
//   i_cmdColor        in   1   command bit0, sampled on i_cmdStart; 1 = luma+chroma, 0 = luma only
//   i_abort           in   1   synchronous abort (MDEC soft reset)
//   i_wordValid       in   1   parameter word available
//   i_word            in   32  parameter word; byte0 = [7:0] is the lowest linear index
//   o_wordReady       out  1   loader accepts i_word this cycle
//   i_pipeBusy        in   1   computeCoef/IDCT still hold coefficients of the current block
//   o_quantWrt        out  1   quant RAM write strobe
//   o_quantValue      out  28  {b3[6:0],b2[6:0],b1[6:0],b0[6:0]}
//   o_quantAdr        out  4   entry index 0..15
//   o_quantTblSelect  out  1   1 = luma table, 0 = chroma table
//   o_busy            out  1   command in progress; stream decoder must not start
//   o_done            out  1   1-cycle pulse after the last entry is written
// BEHAVIOUR
// - Reset: async to IDLE; all outputs 0; counter 0; colour latch 0.
// - States: IDLE, WAITP, LUMA, CHROMA, DONE.
//   - IDLE -> WAITP on i_cmdStart; latch i_cmdColor.
//   - WAITP -> LUMA when !i_pipeBusy (or immediately if GATE_BUSY=0).
//   - LUMA -> CHROMA (colour=1) or DONE (colour=0) on the accept of word TBL_WORDS-1.
//   - CHROMA -> DONE on the accept of word TBL_WORDS-1.
//   - DONE -> IDLE after 1 cycle.
// - o_wordReady = state in {LUMA,CHROMA}, combinational from state only.
//   Accept = o_wordReady & i_wordValid. Stalls on !i_wordValid are unlimited; no timeout.
// - Write latency: 1 cycle. The cycle after an accept, o_quantWrt=1 for exactly 1 cycle.
//   On that cycle o_quantAdr = count at the accept, o_quantTblSelect = (state at the accept == LUMA),
//   and o_quantValue = packed bytes. These outputs are registered and hold when not writing.
// - Counter: 0..TBL_WORDS-1; increments per accept; wraps to 0 on the LUMA->CHROMA transition.
// - o_busy = 1 in WAITP, LUMA, CHROMA and DONE; 0 in IDLE.
// - o_done = registered; high during the DONE state. Coincides with the last o_quantWrt cycle.
// - i_cmdStart outside IDLE is ignored. The colour latch is unchanged.
// - i_abort has priority over every transition, including i_cmdStart in IDLE.
//   Next state is IDLE, no o_done, counter 0.
//   A write already registered from an accept in the abort cycle is dropped: o_quantWrt forced 0.
//   Entries already written stay in the RAM (partial table is legal; the CPU reissues the command).
// - Colour=0: the chroma table is untouched.
// - Byte MSB is discarded silently; a value of 0 is stored as-is.
// TESTING
// - Reset, then cmdStart(color=0), pipeBusy=0, 16 back-to-back words 0x04030201+k*0x04040404.
//   Expect: 16 writes, adr 0..15, tblSel=1; entry 0 = {7'd4,7'd3,7'd2,7'd1}; o_done on the 16th write;
//   busy drops the next cycle.
// - cmdStart(color=1), 32 words with wordValid toggling every other cycle.
//   Expect: writes 0..15 with sel=1, then 0..15 with sel=0; no write on invalid cycles; one o_done.
// - pipeBusy=1 held 10 cycles after cmdStart.
//   Expect: o_wordReady=0 and no write until pipeBusy falls; the first write follows 2 cycles later.
// - Byte 0xFF in every position. Expect: o_quantValue = 28'hFFFFFFF (bit 7 of each byte dropped).
// - Abort asserted on the cycle word 5 of chroma is accepted.
//   Expect: no write for that word, no o_done, IDLE the next cycle; a new cmdStart restarts at adr 0, sel=1.
// - Async i_nrst low mid-LUMA, then a second cmdStart during LOAD.
//   Expect: outputs 0 immediately on reset; the second start is ignored; the sequence completes normally.

Source files
------------

// File: rtl/quant_table_loader.sv
// Loads the MDEC luma/chroma quantisation tables from command-2 parameter words,
// packing four 7-bit factors per word into one 28-bit quant RAM entry.
module quant_table_loader #(
    parameter int  TBL_WORDS = 16,
    parameter bit  GATE_BUSY = 1'b1,
    localparam int CW        = $clog2(TBL_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_cmdStart,
    input  logic          i_cmdColor,
    input  logic          i_abort,
    input  logic          i_wordValid,
    input  logic [31:0]   i_word,
    output logic          o_wordReady,
    input  logic          i_pipeBusy,
    output logic          o_quantWrt,
    output logic [27:0]   o_quantValue,
    output logic [CW-1:0] o_quantAdr,
    output logic          o_quantTblSelect,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITP,
        S_LUMA,
        S_CHROMA,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] count;
    logic          color;
    logic          accept;
    logic          last;
    logic          unused_msbs;

    assign o_wordReady = (state == S_LUMA) || (state == S_CHROMA);
    assign o_busy      = (state != S_IDLE);
    assign accept      = o_wordReady & i_wordValid;
    assign last        = (count == CW'(TBL_WORDS - 1));

    // The top bit of every byte is not part of a quant factor.
    assign unused_msbs = ^{i_word[31], i_word[23], i_word[15], i_word[7]};

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (i_cmdStart) state_nxt = S_WAITP;
            S_WAITP:  if (!GATE_BUSY || !i_pipeBusy) state_nxt = S_LUMA;
            S_LUMA:   if (accept && last) state_nxt = color ? S_CHROMA : S_DONE;
            S_CHROMA: if (accept && last) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        // Abort outranks every transition, including a start in IDLE.
        if (i_abort) state_nxt = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            count <= '0;
            color <= 1'b0;
        end else if (i_abort) begin
            count <= '0;
        end else begin
            if (state == S_IDLE && i_cmdStart) color <= i_cmdColor;
            if (accept) count <= last ? '0 : count + 1'b1;
        end
    end

    // Write port: registered one cycle after the accept, holding between writes.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_quantWrt       <= 1'b0;
            o_quantValue     <= '0;
            o_quantAdr       <= '0;
            o_quantTblSelect <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            o_quantWrt <= accept & ~i_abort;
            o_done     <= (state_nxt == S_DONE);
            if (accept && !i_abort) begin
                o_quantAdr       <= count;
                o_quantTblSelect <= (state == S_LUMA);
                o_quantValue     <= {i_word[30:24], i_word[22:16], i_word[14:8], i_word[6:0]};
            end
        end
    end

endmodule

// File: tb/tb_quant_table_loader.sv
// Directed bench for quant_table_loader: table sequencing, busy gating, byte packing,
// abort and asynchronous reset behaviour.
module tb_quant_table_loader;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    logic        i_cmdStart;
    logic        i_cmdColor;
    logic        i_abort;
    logic        i_wordValid;
    logic [31:0] i_word;
    logic        o_wordReady;
    logic        i_pipeBusy;
    logic        o_quantWrt;
    logic [27:0] o_quantValue;
    logic [3:0]  o_quantAdr;
    logic        o_quantTblSelect;
    logic        o_busy;
    logic        o_done;

    quant_table_loader #(.TBL_WORDS(16), .GATE_BUSY(1'b1)) dut (
        .i_clk           (i_clk),
        .i_nrst          (i_nrst),
        .i_cmdStart      (i_cmdStart),
        .i_cmdColor      (i_cmdColor),
        .i_abort         (i_abort),
        .i_wordValid     (i_wordValid),
        .i_word          (i_word),
        .o_wordReady     (o_wordReady),
        .i_pipeBusy      (i_pipeBusy),
        .o_quantWrt      (o_quantWrt),
        .o_quantValue    (o_quantValue),
        .o_quantAdr      (o_quantAdr),
        .o_quantTblSelect(o_quantTblSelect),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [27:0] pack(input logic [31:0] w);
        return {w[30:24], w[22:16], w[14:8], w[6:0]};
    endfunction

    // Write monitor, sampling 1 time unit after each rising edge.
    int          cyc = 0;
    int          done_count = 0;
    logic        prev_done = 1'b0;
    logic        busy_after_done = 1'b1;
    logic [27:0] cap_val[$];
    logic [3:0]  cap_adr[$];
    logic        cap_sel[$];
    logic        cap_done[$];
    int          cap_cyc[$];
    logic [31:0] sent[$];

    always @(posedge i_clk) begin
        #1;
        cyc++;
        if (o_quantWrt) begin
            cap_val.push_back(o_quantValue);
            cap_adr.push_back(o_quantAdr);
            cap_sel.push_back(o_quantTblSelect);
            cap_done.push_back(o_done);
            cap_cyc.push_back(cyc);
        end
        if (o_done) done_count++;
        if (prev_done) busy_after_done = o_busy;
        prev_done = o_done;
    end

    task automatic clear_log();
        cap_val.delete();
        cap_adr.delete();
        cap_sel.delete();
        cap_done.delete();
        cap_cyc.delete();
        sent.delete();
        done_count      = 0;
        busy_after_done = 1'b1;
    endtask

    task automatic idle_inputs();
        @(negedge i_clk);
        i_cmdStart  = 1'b0;
        i_cmdColor  = 1'b0;
        i_abort     = 1'b0;
        i_wordValid = 1'b0;
    endtask

    task automatic start_cmd(input logic color);
        @(negedge i_clk);
        i_cmdStart = 1'b1;
        i_cmdColor = color;
        @(negedge i_clk);
        i_cmdStart = 1'b0;
        i_cmdColor = 1'b0;
    endtask

    // Presents one word after `gap` invalid cycles and returns once it will be accepted.
    task automatic send_word(input logic [31:0] w, input int gap, input logic abort, input logic start);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge i_clk);
            i_wordValid = 1'b0;
            i_abort     = 1'b0;
            i_cmdStart  = 1'b0;
        end
        @(negedge i_clk);
        i_wordValid = 1'b1;
        i_word      = w;
        i_abort     = abort;
        i_cmdStart  = start;
        i_cmdColor  = start;
        n = 0;
        while (!o_wordReady && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", 32'd0, 32'd1);
        if (!abort) sent.push_back(w);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 500) check("idle_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge i_clk);
    endtask

    // Checks the captured writes against the words sent: adr wraps per table, luma first.
    task automatic verify(input string tag, input int n_exp, input logic exp_done);
        check({tag, "_nwrites"}, cap_val.size(), n_exp);
        for (int i = 0; i < n_exp && i < cap_val.size() && i < sent.size(); i++) begin
            check($sformatf("%s_adr%0d", tag, i), cap_adr[i], i % 16);
            check($sformatf("%s_sel%0d", tag, i), cap_sel[i], (i < 16) ? 1 : 0);
            check($sformatf("%s_val%0d", tag, i), cap_val[i], pack(sent[i]));
            check($sformatf("%s_done%0d", tag, i), cap_done[i], (exp_done && i == n_exp - 1) ? 1 : 0);
        end
        check({tag, "_done_count"}, done_count, exp_done ? 1 : 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wrt"},   o_quantWrt, 0);
        check({tag, "_val"},   o_quantValue, 0);
        check({tag, "_adr"},   o_quantAdr, 0);
        check({tag, "_sel"},   o_quantTblSelect, 0);
        check({tag, "_busy"},  o_busy, 0);
        check({tag, "_done"},  o_done, 0);
        check({tag, "_ready"}, o_wordReady, 0);
    endtask

    initial begin
        int drop_cyc;
        int bad_gaps;
        int ready_seen;
        logic [31:0] t3_words[4];

        i_nrst      = 1'b0;
        i_cmdStart  = 1'b0;
        i_cmdColor  = 1'b0;
        i_abort     = 1'b0;
        i_wordValid = 1'b0;
        i_word      = '0;
        i_pipeBusy  = 1'b0;
        #12;
        check_outputs_zero("reset");
        @(negedge i_clk);
        i_nrst = 1'b1;

        // Luma only, back-to-back words.
        clear_log();
        start_cmd(1'b0);
        for (int k = 0; k < 16; k++) send_word(32'h04030201 + k * 32'h04040404, 0, 1'b0, 1'b0);
        idle_inputs();
        wait_idle();
        verify("luma", 16, 1'b1);
        if (cap_val.size() > 0) check("luma_entry0", cap_val[0], {7'd4, 7'd3, 7'd2, 7'd1});
        check("luma_busy_after_done", busy_after_done, 0);

        // Luma + chroma with wordValid toggling every other cycle.
        clear_log();
        start_cmd(1'b1);
        for (int k = 0; k < 32; k++) send_word(32'h11223344 + k * 32'h01030507, 1, 1'b0, 1'b0);
        idle_inputs();
        wait_idle();
        verify("color", 32, 1'b1);
        bad_gaps = 0;
        for (int i = 1; i < cap_cyc.size(); i++)
            if (cap_cyc[i] - cap_cyc[i-1] != 2) bad_gaps++;
        check("color_write_spacing", bad_gaps, 0);

        // Pipe busy gating, plus byte-MSB dropping.
        clear_log();
        t3_words[0] = 32'hFFFFFFFF;
        t3_words[1] = 32'h80808080;
        t3_words[2] = 32'h00000000;
        t3_words[3] = 32'h7F807F80;
        i_pipeBusy  = 1'b1;
        start_cmd(1'b0);
        ready_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            i_wordValid = 1'b1;
            i_word      = t3_words[0];
            if (o_wordReady) ready_seen++;
        end
        check("gate_ready_low", ready_seen, 0);
        check("gate_no_write", cap_val.size(), 0);
        i_pipeBusy = 1'b0;
        drop_cyc   = cyc;
        for (int k = 0; k < 16; k++) send_word(t3_words[k % 4], 0, 1'b0, 1'b0);
        idle_inputs();
        wait_idle();
        verify("gate", 16, 1'b1);
        if (cap_cyc.size() > 0) check("gate_first_write_latency", cap_cyc[0] - drop_cyc, 2);
        if (cap_val.size() > 3) begin
            check("bytes_ff", cap_val[0], 28'hFFFFFFF);
            check("bytes_80", cap_val[1], 28'h0000000);
            check("bytes_7f80", cap_val[3], 28'hFE03F80);
        end

        // Abort on the accept of chroma word 5.
        clear_log();
        start_cmd(1'b1);
        for (int k = 0; k < 21; k++) send_word(32'h01010101 * (k + 1), 0, 1'b0, 1'b0);
        send_word(32'h55555555, 0, 1'b1, 1'b0);
        idle_inputs();
        check("abort_busy_next", o_busy, 0);
        check("abort_ready_next", o_wordReady, 0);
        check("abort_no_write", o_quantWrt, 0);
        repeat (4) @(negedge i_clk);
        verify("abort", 21, 1'b0);
        clear_log();
        start_cmd(1'b0);
        for (int k = 0; k < 16; k++) send_word(32'h0A0B0C0D + k, 0, 1'b0, 1'b0);
        idle_inputs();
        wait_idle();
        verify("restart", 16, 1'b1);

        // Asynchronous reset mid-luma, then a start during loading is ignored.
        clear_log();
        start_cmd(1'b1);
        for (int k = 0; k < 5; k++) send_word(32'h20202020 + k, 0, 1'b0, 1'b0);
        #2;
        i_nrst = 1'b0;
        #1;
        check_outputs_zero("async_rst");
        i_wordValid = 1'b0;
        @(negedge i_clk);
        i_nrst = 1'b1;
        clear_log();
        start_cmd(1'b0);
        for (int k = 0; k < 16; k++) send_word(32'h30313233 + k * 32'h00010000, 0, 1'b0, k == 3);
        idle_inputs();
        wait_idle();
        verify("second_start", 16, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
